// File: rtl/rv_muldiv_if.sv
// Request/result handshake bundle for the iterative RV32M multiply/divide unit.
interface rv_muldiv_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, funct3, rs1, rs2, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, funct3, rs1, rs2, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module rv_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   rv_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       f3_q, f3_d;
   logic [XLEN-1:0]  op_q, op_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic             neg_q, neg_d, rneg_q, rneg_d;

   function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   // Operand decode on the accept edge: signedness, magnitudes, fast-path detection.
   logic            is_div, s1, s2, sgn1, sgn2, div0, ovf;
   logic [XLEN-1:0] mag1, mag2, fast_res;

   always_comb begin
      is_div   = bus.funct3[2];
      s1       = (bus.funct3 != 3'b011) && !(bus.funct3[2] && bus.funct3[0]);
      s2       = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      sgn1     = s1 && bus.rs1[XLEN-1];
      sgn2     = s2 && bus.rs2[XLEN-1];
      mag1     = sgn1 ? -bus.rs1 : bus.rs1;
      mag2     = sgn2 ? -bus.rs2 : bus.rs2;
      div0     = is_div && (bus.rs2 == '0);
      ovf      = is_div && !bus.funct3[0] && (bus.rs1 == SMIN) && (bus.rs2 == '1);
      fast_res = div0 ? (bus.funct3[1] ? bus.rs1 : '1) : (bus.funct3[1] ? '0 : SMIN);
   end

   // One iteration: hi holds partial product / partial remainder, lo the multiplier / quotient.
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [XLEN-1:0]   hi_n, lo_n, quo, rem;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
      div_sh   = {hi_q, lo_q[XLEN-1]};
      div_diff = div_sh - {1'b0, op_q};
      if (f3_q[2]) begin
         hi_n = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
         {hi_n, lo_n} = {mul_sum, lo_q[XLEN-1:1]};
      end
      prod = cond_neg({hi_n, lo_n}, neg_q);
      quo  = neg_q  ? -lo_n : lo_n;
      rem  = rneg_q ? -hi_n : hi_n;
      if (f3_q[2])              final_res = f3_q[1] ? rem : quo;
      else if (f3_q == 3'b000)  final_res = prod[XLEN-1:0];
      else                      final_res = prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            f3_d   = bus.funct3;
            cnt_d  = '0;
            hi_d   = '0;
            neg_d  = sgn1 ^ sgn2;
            rneg_d = sgn1;
            if (div0 || ovf) begin
               state_d  = DONE;
               result_d = fast_res;
            end else begin
               state_d = CALC;
               op_d    = is_div ? mag2 : mag1;
               lo_d    = is_div ? mag1 : mag2;
            end
         end
         CALC: begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.result    = result_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomized and directed bench for rv_muldiv_unit against an arithmetic reference model.
module tb_rv_muldiv_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   rv_muldiv_if #(.XLEN(32)) bus ();
   rv_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, zb, sp;
      logic [63:0] ua, ub, up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      zb = {32'b0, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'b000: begin sp = sa * sb; return sp[31:0]; end
         3'b001: begin sp = sa * sb; return sp[63:32]; end
         3'b010: begin sp = sa * zb; return sp[63:32]; end
         3'b011: begin up = ua * ub; return up[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sp = sa / sb; return sp[31:0];
         end
         3'b101: begin
            if (b == 0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sp = sa % sb; return sp[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua % ub; return up[31:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp;
      bit          fast;
      int          lat;
      exp  = ref_op(f, a, b);
      fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      wait_ready();
      bus.in_valid  = 1'b1;
      bus.funct3    = f;
      bus.rs1       = a;
      bus.rs2       = b;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.funct3   = 3'($urandom);
      bus.rs1      = $urandom;
      bus.rs2      = $urandom;
      if (!fast) begin
         chk("calc_busy", bus.busy, 1);
         chk("calc_in_ready", bus.in_ready, 0);
      end
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("lat f%0d", f), lat, fast ? 0 : 32);
      chk($sformatf("res f%0d %h %h", f, a, b), bus.result, exp);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.funct3   = 3'($urandom);
         bus.rs1      = $urandom;
         bus.rs2      = $urandom;
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_result", bus.result, exp);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_valid", bus.out_valid, 0);
      chk("post_in_ready", bus.in_ready, 1);
      chk("post_result_kept", bus.result, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_result", bus.result, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'b101, 32'd100, 32'd7, 0);
      run_op(3'b111, 32'd100, 32'd7, 0);
      run_op(3'b100, 32'd5, 32'd0, 0);
      run_op(3'b110, 32'd5, 32'd0, 0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b101, 32'd9, 32'd0, 0);
      run_op(3'b111, 32'd9, 32'd0, 0);
      run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 10);

      // Reset in the middle of an iterative operation
      wait_ready();
      bus.in_valid = 1'b1;
      bus.funct3   = 3'b000;
      bus.rs1      = 32'd3;
      bus.rs2      = 32'd5;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_result", bus.result, 0);
      @(negedge clk);
      reset_n = 1'b1;
      begin
         int seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
         end
         chk("abort_no_valid", seen, 0);
      end
      chk("abort_ready_after", bus.in_ready, 1);
      run_op(3'b101, 32'd100, 32'd7, 0);

      for (int i = 0; i < 200; i++)
         run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
